// File: rtl/seq_serializer.sv
// MSB-first parallel-to-serial front end with a one-word holding buffer for gapless streaming.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after every word.
module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             done
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]        GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

`ifdef SEQ_SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_GAP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic [3:0]         gap_q, gap_d;
`ifdef SEQ_SER_PARITY_EN
    logic               par_q, par_d;
`endif

    logic               accept;
    logic               eow;
    logic               gap_end;
    logic               ld_en;
    logic               took_din;
    logic [WIDTH-1:0]   ld_src;

    // ready depends on registered state only, so load never combinationally reaches it.
    assign ready  = !buf_full_q;
    assign accept = load && ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a missing branch would infer a latch.
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        gap_d      = gap_q;
`ifdef SEQ_SER_PARITY_EN
        par_d      = par_q;
`endif
        x_out      = 1'b0;
        bit_valid  = 1'b0;
        done       = 1'b0;
        eow        = 1'b0;
        gap_end    = 1'b0;
        ld_en      = 1'b0;
        took_din   = 1'b0;
        ld_src     = din;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ld_en    = 1'b1;
                    took_din = 1'b1;
                end
            end
            S_SHIFT: begin
                x_out     = shreg_q[WIDTH-1];
                bit_valid = 1'b1;
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef SEQ_SER_PARITY_EN
                    state_d = S_PARITY;
`else
                    done    = 1'b1;
                    eow     = 1'b1;
`endif
                end
            end
`ifdef SEQ_SER_PARITY_EN
            S_PARITY: begin
                x_out     = par_q;
                bit_valid = 1'b1;
                done      = 1'b1;
                eow       = 1'b1;
            end
`endif
            S_GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == GAP_LAST) gap_end = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A load landing on the final gap edge bypasses too, so a word is never stranded in the buffer.
        if (eow && (GAP > 0)) begin
            state_d = S_GAP;
            gap_d   = 4'd0;
        end else if (eow || gap_end) begin
            if (buf_full_q) begin
                ld_en      = 1'b1;
                ld_src     = buf_q;
                buf_full_d = 1'b0;
            end else if (accept) begin
                ld_en    = 1'b1;
                took_din = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (ld_en) begin
            shreg_d = ld_src;
            cnt_d   = '0;
            state_d = S_SHIFT;
`ifdef SEQ_SER_PARITY_EN
            par_d   = ^ld_src;
`endif
        end

        if (accept && !took_din) begin
            buf_d      = din;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are reset as well, so the serial line is clean straight out of reset.
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            gap_q      <= '0;
`ifdef SEQ_SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            gap_q      <= gap_d;
`ifdef SEQ_SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: a GAP=0 instance streams directed words, a GAP=2 instance checks idle gaps.
module tb_seq_serializer;

    localparam int W = 8;
`ifdef SEQ_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L = W + P;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din = '0;
    logic         load = 1'b0;
    logic         ready, x_out, bit_valid, done;

    logic [W-1:0] din_g = '0;
    logic         load_g = 1'b0;
    logic         ready_g, x_g, v_g, d_g;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(W), .GAP(0)) dut (
        .clk(clk), .reset(reset), .din(din), .load(load),
        .ready(ready), .x_out(x_out), .bit_valid(bit_valid), .done(done)
    );

    seq_serializer #(.WIDTH(W), .GAP(2)) u_gap (
        .clk(clk), .reset(reset), .din(din_g), .load(load_g),
        .ready(ready_g), .x_out(x_g), .bit_valid(v_g), .done(d_g)
    );

    typedef struct packed {
        logic x;
        logic d;
    } exp_bit_t;

    exp_bit_t sb[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    int       n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) sb.push_back('{x: w[i], d: (P == 0 && i == 0)});
        if (P == 1) sb.push_back('{x: ^w, d: 1'b1});
    endtask

    // Expected (valid, x, done) of the GAP=2 instance, k cycles after 8'hA5 is accepted.
    function automatic logic [2:0] gap_expect(input int k);
        logic [W-1:0] w;
        int           b;
        if (k <= L) begin
            w = 8'hA5;
            b = k - 1;
        end else if (k <= L + 2 || k > 2 * L + 2) begin
            return 3'b000;
        end else begin
            w = 8'h07;
            b = k - L - 3;
        end
        if (b < W) return {1'b1, w[W-1-b], (P == 0 && b == W - 1)};
        return {1'b1, ^w, 1'b1};
    endfunction

    always @(negedge clk) begin
        exp_bit_t e;
        if (!reset) begin
            if (bit_valid) begin
                check("sb_empty_on_bit", 32'(sb.size() == 0), 32'd0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("x_out", 32'(x_out), 32'(e.x));
                    check("done_bit", 32'(done), 32'(e.d));
                end
            end else begin
                check("done_idle", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        logic [2:0] ge;

        tick();
        check("rst_x_out", 32'(x_out), 32'd0);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        tick();

        // Single word.
        din = 8'hA5; load = 1'b1; push_word(8'hA5);
        tick();
        load = 1'b0;
        for (int j = 1; j <= L; j++) begin
            check("t1_valid", 32'(bit_valid), 32'd1);
            check("t1_done", 32'(done), 32'(j == L));
            check("t1_ready", 32'(ready), 32'd1);
            tick();
        end
        check("t1_idle_valid", 32'(bit_valid), 32'd0);
        check("t1_sb_drained", 32'(sb.size()), 32'd0);
        tick();

        // Back-to-back words, with an ignored load while the buffer is full.
        din = 8'hA5; load = 1'b1; push_word(8'hA5);
        tick();
        for (int j = 1; j <= 2 * L; j++) begin
            check("t2_valid", 32'(bit_valid), 32'd1);
            check("t2_done", 32'(done), 32'(j == L || j == 2 * L));
            check("t2_ready", 32'(ready), 32'((j >= 3 && j <= L) ? 0 : 1));
            if (j == 2) begin
                din = 8'h3C; load = 1'b1; push_word(8'h3C);
            end else if (j == 4) begin
                din = 8'hFF; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        check("t2_idle_valid", 32'(bit_valid), 32'd0);
        check("t2_idle_ready", 32'(ready), 32'd1);
        check("t2_sb_drained", 32'(sb.size()), 32'd0);
        tick();

        // Reset in the 4th bit with a word buffered.
        din = 8'hA5; load = 1'b1; push_word(8'hA5);
        tick();
        load = 1'b0;
        tick();
        din = 8'h3C; load = 1'b1; push_word(8'h3C);
        tick();
        load = 1'b0;
        tick();
        check("t3_pre_valid", 32'(bit_valid), 32'd1);
        check("t3_pre_ready", 32'(ready), 32'd0);
        check("t3_pre_x", 32'(x_out), 32'd0);
        reset = 1'b1;
        sb.delete();
        #1;
        check("t3_rst_x_out", 32'(x_out), 32'd0);
        check("t3_rst_valid", 32'(bit_valid), 32'd0);
        check("t3_rst_done", 32'(done), 32'd0);
        check("t3_rst_ready", 32'(ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        din = 8'h01; load = 1'b1; push_word(8'h01);
        tick();
        load = 1'b0;
        for (int j = 1; j <= L; j++) begin
            check("t3_valid", 32'(bit_valid), 32'd1);
            check("t3_done", 32'(done), 32'(j == L));
            tick();
        end
        check("t3_idle_valid", 32'(bit_valid), 32'd0);
        check("t3_sb_drained", 32'(sb.size()), 32'd0);

        // Inter-word gap on the GAP=2 instance.
        din_g = 8'hA5; load_g = 1'b1;
        tick();
        for (int k = 1; k <= 2 * L + 4; k++) begin
            ge = gap_expect(k);
            check("gap_valid", 32'(v_g), 32'(ge[2]));
            check("gap_x", 32'(x_g), 32'(ge[1]));
            check("gap_done", 32'(d_g), 32'(ge[0]));
            if (k == 1) begin
                din_g = 8'h07; load_g = 1'b1;
            end else begin
                load_g = 1'b0;
            end
            tick();
        end
        check("gap_ready_end", 32'(ready_g), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the sequence detector stage. It accepts WIDTH-bit words over a load/ready handshake and shifts them MSB-first onto a single serial bit line, one bit per clk. That line feeds the detector's serial input `x`. A one-word holding buffer allows back-to-back words with no idle bits between them.

## Interface
- WIDTH, 8: data word width; legal range is 2 to 32.
- GAP, 0: number of idle cycles inserted between consecutive words; legal range is 0 to 15.
- clk  input  1  Single clock; all state changes on posedge.
- reset  input  1  Asynchronous, active-high reset.
- din  input  WIDTH  Parallel word, sampled when load && ready at posedge clk.
- load  input  1  Word-offer strobe.
- ready  output  1  Block can accept a word this cycle.
- x_out  output  1  Serial bit; connects to the detector's `x`.
- bit_valid  output  1  x_out carries a data or parity bit this cycle.
- done  output  1  High for exactly the cycle in which a word's final bit is on x_out.

## Operation
- Reset values: state=IDLE, x_out=0, bit_valid=0, done=0, ready=1, shift register=0, bit counter=0, buffer empty.
- Storage:
  - shift register, WIDTH bits, always shifts left;
  - bit counter, $clog2(WIDTH+1) bits;
  - holding buffer, WIDTH bits plus a full flag;
  - gap counter, 4 bits.
- ready = !buffer_full. This is a combinational function of registers only, with no path from load.
- States:
  - IDLE: bit_valid=0 and x_out=0. An accepted load copies din into the shift register and moves to SHIFT.
  - SHIFT: x_out=shreg[WIDTH-1] and bit_valid=1. The counter runs from 0 to WIDTH-1. At count WIDTH-1 (the last bit):
    - with the parity macro enabled, go to PARITY;
    - otherwise, perform the end-of-word step.
  - PARITY (macro only): x_out = XOR of the word, i.e. even parity, with bit_valid=1. Then perform the end-of-word step.
  - GAP: x_out=0 and bit_valid=0 for GAP cycles. Then:
    - if the buffer is full, load the shift register from the buffer and go to SHIFT;
    - else go to IDLE.
- End-of-word step (at the edge ending the last bit):
  - GAP>0: go to GAP.
  - GAP=0 and buffer full: load the shift register from the buffer, clear the buffer, go to SHIFT.
  - GAP=0, buffer empty, load accepted this same edge: din bypasses directly into the shift register; go to SHIFT.
  - Otherwise: go to IDLE.
- Any load accepted outside IDLE (and not bypassed) is written to the buffer and sets buffer_full.
  - A load while ready=0 is ignored. The buffer is never overwritten.
  - Buffer writes and buffer drains in the same edge cannot collide, because ready=0 whenever the buffer is full.
- done is asserted on the last data bit, or on the parity bit when the macro is enabled.

## Timing
- Acceptance edge N: the first bit (MSB) is on x_out with bit_valid=1 during cycle N+1.
- The last data bit is present in cycle N+WIDTH. The parity bit, if enabled, is present in cycle N+WIDTH+1.
- Throughput with GAP=0 and continuous load: WIDTH bits per WIDTH cycles, or WIDTH+1 bits with parity. No bubble between words.
- The buffer is filled at the acceptance edge, so ready falls in the following cycle. ready rises in the cycle after the buffer drains.
- Reset mid-word: all outputs reach their reset values immediately, without waiting for clk. The partial word and the buffered word are discarded.
- The first posedge after reset deasserts acts from IDLE.

## Configuration
- SEQ_SER_PARITY_EN defined: the PARITY state exists, and every word is followed by one even-parity bit with bit_valid=1. done moves to the parity cycle.
- SEQ_SER_PARITY_EN undefined: the PARITY state and its logic are compiled out. Words are exactly WIDTH bits.

## Test plan
- Single word, parity off, WIDTH=8, GAP=0: load 8'hA5 at edge N.
  - Required: x_out = 1,0,1,0,0,1,0,1 in cycles N+1..N+8, bit_valid=1 throughout.
  - done only in cycle N+8; IDLE from cycle N+9 (bit_valid=0).
- Back-to-back words: load 8'hA5, then 8'h3C in cycle N+2.
  - Required: 16 contiguous valid bits, with the 3C bits 0,0,1,1,1,1,0,0 in cycles N+9..N+16.
  - ready=0 from cycle N+3 through N+8.
  - done in cycles N+8 and N+16.
- Load while full: with the buffer holding 8'h3C, pulse load with din=8'hFF.
  - Required: ready stays 0, and 8'hFF never appears on x_out.
- Reset mid-word: assert reset during the 4th bit of 8'hA5.
  - Required: x_out=0, bit_valid=0, done=0 and ready=1 immediately.
  - After release, a new load of 8'h01 serializes correctly starting from its MSB.
- Parity and gap (SEQ_SER_PARITY_EN, GAP=2): load 8'hA5, then 8'h07.
  - Required: 8'hA5 is followed by a parity bit of 0, then 2 cycles with bit_valid=0.
  - 8'h07 is followed by a parity bit of 1, with done on each parity cycle.
